// File: rtl/fetch_unit.sv
// Stage-1 instruction fetch: owns the PC, issues credit-limited in-order word reads,
// buffers responses and presents one registered instruction (or a NOP bubble) per cycle.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] line,
    output logic [31:0] line_pc,
    output logic        line_valid
);

    localparam int          PW  = $clog2(BUF_DEPTH);
    localparam int          CW  = PW + 1;
    localparam int          SW  = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] buf_count;
    logic [PW-1:0] buf_head;
    logic [PW-1:0] buf_tail;
    logic [PW-1:0] pcq_head;
    logic [PW-1:0] pcq_tail;

    logic [31:0] buf_data [BUF_DEPTH];
    logic [31:0] buf_pc   [BUF_DEPTH];
    logic [31:0] pcq_mem  [BUF_DEPTH];

    logic credit_ok;
    logic req_fire;
    logic resp_keep;
    logic out_update;
    logic buf_empty;
    logic bypass;
    logic pop;
    logic push;

    // Low address bits of the redirect target are forced to zero and never read.
    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        credit_ok      = ({1'b0, inflight} + {1'b0, buf_count}) < DEPTH_S;
        imem_req_valid = !reset && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_keep      = imem_resp_valid && !redirect_valid && (drop == '0);
        out_update     = !redirect_valid && (!stall || !line_valid);
        buf_empty      = (buf_count == '0);
        bypass         = out_update && buf_empty && resp_keep;
        pop            = out_update && !buf_empty;
        push           = resp_keep && !bypass;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            inflight   <= '0;
            drop       <= '0;
            buf_count  <= '0;
            buf_head   <= '0;
            buf_tail   <= '0;
            pcq_head   <= '0;
            pcq_tail   <= '0;
            line       <= NOP;
            line_pc    <= '0;
            line_valid <= 1'b0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
            pcq_tail <= pcq_tail + PW'(req_fire);
            pcq_head <= pcq_head + PW'(imem_resp_valid);

            if (redirect_valid) begin
                // Everything still outstanding is stale; the PC queue keeps draining with it.
                fetch_pc   <= {redirect_pc[31:2], 2'b00};
                drop       <= inflight - CW'(imem_resp_valid);
                buf_count  <= '0;
                buf_head   <= '0;
                buf_tail   <= '0;
                line       <= NOP;
                line_valid <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                buf_count <= buf_count + CW'(push) - CW'(pop);
                buf_head  <= buf_head + PW'(pop);
                buf_tail  <= buf_tail + PW'(push);

                if (out_update) begin
                    if (pop) begin
                        line       <= buf_data[buf_head];
                        line_pc    <= buf_pc[buf_head];
                        line_valid <= 1'b1;
                    end else if (bypass) begin
                        line       <= imem_resp_data;
                        line_pc    <= pcq_mem[pcq_head];
                        line_valid <= 1'b1;
                    end else begin
                        line       <= NOP;
                        line_valid <= 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone decide what is valid.
    always_ff @(posedge clock) begin
        if (req_fire) begin
            pcq_mem[pcq_tail] <= fetch_pc;
        end
        if (push) begin
            buf_data[buf_tail] <= imem_resp_data;
            buf_pc[buf_tail]   <= pcq_mem[pcq_head];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable in-order memory that returns the
// request address as data, plus one task per scenario with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] line;
    logic [31:0] line_pc;
    logic        line_valid;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .line           (line),
        .line_pc        (line_pc),
        .line_valid     (line_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // In-order memory: data = address, response mem_lat cycles after the accepting edge.
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          ecount;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
            ecount = 0;
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
        end else begin
            ecount = ecount + 1;
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(ecount + mem_lat - 1);
            end
            if (mq_due.size() > 0 && mq_due[0] <= ecount) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mq_addr.pop_front();
                void'(mq_due.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic do_reset(input int lat, input logic rdy);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = rdy;
        mem_lat        = lat;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        total++; if (line !== NOP) begin bad++; $display("FAIL reset_line: got %h want %h", line, NOP); end
        total++; if (line_pc !== 32'h0) begin bad++; $display("FAIL reset_line_pc: got %h want 0", line_pc); end
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_line_valid: got %b want 0", line_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    endtask

    task automatic test_stream;
        logic [31:0] exp;
        do_reset(1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(negedge clock); #1; end
            exp = 32'(4 * i);
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp) begin
                bad++; $display("FAIL stream_req[%0d]: got v=%b a=%h want v=1 a=%h", i, imem_req_valid, imem_req_addr, exp);
            end
            exp = (i >= 2) ? 32'(4 * (i - 2)) : NOP;
            total++; if (line_valid !== (i >= 2) || line !== exp) begin
                bad++; $display("FAIL stream_line[%0d]: got v=%b l=%h want v=%b l=%h", i, line_valid, line, (i >= 2), exp);
            end
            if (i >= 2) begin
                total++; if (line_pc !== exp) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, line_pc, exp); end
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] exp;
        do_reset(1, 1'b1);
        repeat (4) @(negedge clock);
        stall = 1'b1;
        #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h8) begin bad++; $display("FAIL stall_start_line: got v=%b l=%h want v=1 l=8", line_valid, line); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin bad++; $display("FAIL stall_start_req: got v=%b a=%h want v=1 a=10", imem_req_valid, imem_req_addr); end
        for (int k = 5; k <= 9; k++) begin
            @(negedge clock); #1;
            total++; if (line_valid !== 1'b1 || line !== 32'h8 || line_pc !== 32'h8) begin
                bad++; $display("FAIL stall_hold[%0d]: got v=%b l=%h pc=%h want v=1 l=8 pc=8", k, line_valid, line, line_pc);
            end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_credit[%0d]: got req_valid=%b want 0", k, imem_req_valid); end
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            exp = 32'hC + 32'(4 * k);
            total++; if (line_valid !== 1'b1 || line !== exp || line_pc !== exp) begin
                bad++; $display("FAIL stall_release[%0d]: got v=%b l=%h pc=%h want v=1 l=pc=%h", k, line_valid, line, line_pc, exp);
            end
        end
    endtask

    task automatic test_redirect;
        do_reset(3, 1'b1);
        repeat (2) @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_wait: got req_valid=%b want 0", imem_req_valid); end
        for (int k = 3; k <= 7; k++) begin
            if (k > 3) begin @(negedge clock); #1; end
            total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL redir_stale[%0d]: got v=%b pc=%h want v=0", k, line_valid, line_pc); end
            if (k == 4) begin
                total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
                    bad++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=100", imem_req_valid, imem_req_addr);
                end
            end
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line_pc !== 32'h100 || line !== 32'h100) begin
            bad++; $display("FAIL redir_first: got v=%b l=%h pc=%h want v=1 l=pc=100", line_valid, line, line_pc);
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line_pc !== 32'h104) begin
            bad++; $display("FAIL redir_second: got v=%b pc=%h want v=1 pc=104", line_valid, line_pc);
        end
    endtask

    task automatic test_ready_low;
        do_reset(1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clock); #1; end
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                bad++; $display("FAIL nordy_req[%0d]: got v=%b a=%h want v=1 a=0", k, imem_req_valid, imem_req_addr);
            end
            total++; if (line_valid !== 1'b0 || line !== NOP) begin
                bad++; $display("FAIL nordy_line[%0d]: got v=%b l=%h want v=0 l=%h", k, line_valid, line, NOP);
            end
        end
        imem_req_ready = 1'b1;
        @(negedge clock); #1;
        total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL nordy_next: got a=%h want 4", imem_req_addr); end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h0) begin bad++; $display("FAIL nordy_line: got v=%b l=%h want v=1 l=0", line_valid, line); end
    endtask

    task automatic test_redirect_collide;
        do_reset(1, 1'b1);
        repeat (4) @(negedge clock);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL coll_noreq: got req_valid=%b want 0", imem_req_valid); end
        @(negedge clock);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        total++; if (line_valid !== 1'b0 || line !== NOP || line_pc !== 32'h8) begin
            bad++; $display("FAIL coll_line: got v=%b l=%h pc=%h want v=0 l=%h pc=8", line_valid, line, line_pc, NOP);
        end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            bad++; $display("FAIL coll_req: got v=%b a=%h want v=1 a=40", imem_req_valid, imem_req_addr);
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL coll_stale: got v=%b l=%h want v=0", line_valid, line); end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h40 || line_pc !== 32'h40) begin
            bad++; $display("FAIL coll_target: got v=%b l=%h pc=%h want v=1 l=pc=40", line_valid, line, line_pc);
        end
    endtask

    task automatic test_back_to_back;
        do_reset(3, 1'b1);
        repeat (2) @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clock);
        redirect_pc    = 32'h0000_0300;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
            bad++; $display("FAIL b2b_req: got v=%b a=%h want v=1 a=300", imem_req_valid, imem_req_addr);
        end
        for (int k = 4; k <= 7; k++) begin
            if (k > 4) begin @(negedge clock); #1; end
            total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL b2b_stale[%0d]: got v=%b pc=%h want v=0", k, line_valid, line_pc); end
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line_pc !== 32'h300 || line !== 32'h300) begin
            bad++; $display("FAIL b2b_first: got v=%b l=%h pc=%h want v=1 l=pc=300", line_valid, line, line_pc);
        end
    endtask

    task automatic test_wrap;
        do_reset(1, 1'b1);
        repeat (2) @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req0: got v=%b a=%h want v=1 a=fffffffc", imem_req_valid, imem_req_addr);
        end
        @(negedge clock); #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_req1: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line_pc !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_line0: got v=%b pc=%h want v=1 pc=fffffffc", line_valid, line_pc);
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line_pc !== 32'h0 || line !== 32'h0) begin
            bad++; $display("FAIL wrap_line1: got v=%b l=%h pc=%h want v=1 l=pc=0", line_valid, line, line_pc);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1, 1'b1);
        repeat (4) @(negedge clock);
        stall = 1'b1;
        @(negedge clock);
        #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h8) begin bad++; $display("FAIL rmid_pre: got v=%b l=%h want v=1 l=8", line_valid, line); end
        reset = 1'b1;
        #1;
        total++; if (line !== NOP || line_pc !== 32'h0 || line_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_async: got v=%b l=%h pc=%h want v=0 l=%h pc=0", line_valid, line, line_pc, NOP);
        end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req: got req_valid=%b want 0", imem_req_valid); end
        stall = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL rmid_restart: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr);
        end
        repeat (2) @(negedge clock);
        #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h0 || line_pc !== 32'h0) begin
            bad++; $display("FAIL rmid_first: got v=%b l=%h pc=%h want v=1 l=pc=0", line_valid, line, line_pc);
        end
        @(negedge clock); #1;
        total++; if (line_valid !== 1'b1 || line !== 32'h4) begin
            bad++; $display("FAIL rmid_second: got v=%b l=%h want v=1 l=4", line_valid, line);
        end
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_ready_low();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
